// File: rtl/mini_aes_pkg.sv
// Shared types and nibble-level helpers for the 16-bit Mini-AES round sequencer.
package mini_aes_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned NIB_W  = 4;

    typedef logic [NIB_W-1:0]  nibble_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD0,
        S_SUB,
        S_MC_LOAD,
        S_MC_WAIT,
        S_ADDK,
        S_DONE
    } state_t;

    localparam nibble_t SBOX_TBL [16] = '{
        4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
        4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
    };

    // Index is the round number; entries past round 8 are unused.
    localparam nibble_t RCON_TBL [16] = '{
        4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC,
        4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0
    };

    function automatic nibble_t sbox(input nibble_t x);
        return SBOX_TBL[x];
    endfunction

    function automatic nibble_t rcon(input logic [3:0] r);
        return RCON_TBL[r];
    endfunction

    function automatic word_t shift_row(input word_t s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic word_t nib_sub16(input word_t s);
        return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
    endfunction

endpackage

// File: rtl/mini_aes_ctrl_if.sv
// Command and Mix_Column handshake bundle for mini_aes_ctrl.
interface mini_aes_ctrl_if;
    logic        start;
    logic [15:0] pt;
    logic [15:0] key;
    logic        busy;
    logic [15:0] ct;
    logic        done;
    logic        err;
    logic [15:0] mc_c;
    logic        mc_ld;
    logic [15:0] mc_d;
    logic        mc_dn;

    modport master (
        output start, pt, key, mc_d, mc_dn,
        input  busy, ct, done, err, mc_c, mc_ld
    );

    modport slave (
        input  start, pt, key, mc_d, mc_dn,
        output busy, ct, done, err, mc_c, mc_ld
    );
endinterface

// File: rtl/mini_aes_key_step.sv
// Combinational Mini-AES key schedule step: previous round key and round number to next key.
module mini_aes_key_step
    import mini_aes_pkg::*;
#(
    parameter int unsigned RW = 2
) (
    input  logic [15:0]   key_prev,
    input  logic [RW-1:0] rnd,
    output logic [15:0]   key_next_c
);
    nibble_t w4, w5, w6, w7;

    always_comb begin
        w4 = key_prev[15:12] ^ sbox(key_prev[3:0]) ^ rcon(4'(rnd));
        w5 = key_prev[11:8] ^ w4;
        w6 = key_prev[7:4] ^ w5;
        w7 = key_prev[3:0] ^ w6;
        key_next_c = {w4, w5, w6, w7};
    end
endmodule

// File: rtl/mini_aes_ctrl.sv
// Mini-AES round sequencer; hands non-final rounds to an external Mix_Column block.
// Optional MixColumn watchdog enabled by defining MINI_AES_MC_TIMEOUT_EN.
module mini_aes_ctrl
    import mini_aes_pkg::*;
#(
    parameter int unsigned ROUNDS  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           n_rst,
    mini_aes_ctrl_if.slave bus
);
    localparam int unsigned RW = $clog2(ROUNDS + 1);

    if (ROUNDS < 1 || ROUNDS > 8) begin : g_chk_rounds
        $error("mini_aes_ctrl: ROUNDS must be in 1..8");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("mini_aes_ctrl: TIMEOUT must be at least 1");
    end

    state_t        st;
    logic [15:0]   state_q;
    logic [15:0]   key_q;
    logic [15:0]   ct_q;
    logic [15:0]   key_nxt;
    logic [RW-1:0] rnd;
    logic          busy_q;
    logic          done_q;
    logic          mc_ld_q;

`ifdef MINI_AES_MC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          to_flag;
    logic          err_q;
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    mini_aes_key_step #(.RW(RW)) u_key_step (
        .key_prev   (key_q),
        .rnd        (rnd),
        .key_next_c (key_nxt)
    );

    // Round sequencer: state word and round key are updated in place.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            st      <= S_IDLE;
            state_q <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            rnd     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mc_ld_q <= 1'b0;
`ifdef MINI_AES_MC_TIMEOUT_EN
            to_cnt  <= '0;
            to_flag <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            mc_ld_q <= 1'b0;
`ifdef MINI_AES_MC_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (st)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= bus.pt;
                        key_q   <= bus.key;
                        busy_q  <= 1'b1;
`ifdef MINI_AES_MC_TIMEOUT_EN
                        to_flag <= 1'b0;
`endif
                        st      <= S_ADD0;
                    end
                end
                S_ADD0: begin
                    state_q <= state_q ^ key_q;
                    rnd     <= RW'(1);
                    st      <= S_SUB;
                end
                S_SUB: begin
                    state_q <= shift_row(nib_sub16(state_q));
                    key_q   <= key_nxt;
                    if (rnd < RW'(ROUNDS)) begin
                        mc_ld_q <= 1'b1;
`ifdef MINI_AES_MC_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                        st      <= S_MC_LOAD;
                    end else begin
                        st      <= S_ADDK;
                    end
                end
                S_MC_LOAD: st <= S_MC_WAIT;
                S_MC_WAIT: begin
                    if (bus.mc_dn) begin
                        state_q <= bus.mc_d;
                        st      <= S_ADDK;
                    end
`ifdef MINI_AES_MC_TIMEOUT_EN
                    else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        to_flag <= 1'b1;
                        st      <= S_DONE;
                    end else begin
                        to_cnt  <= to_cnt + TW'(1);
                    end
`endif
                end
                S_ADDK: begin
                    state_q <= state_q ^ key_q;
                    if (rnd == RW'(ROUNDS)) begin
                        st <= S_DONE;
                    end else begin
                        rnd <= rnd + RW'(1);
                        st  <= S_SUB;
                    end
                end
                S_DONE: begin
`ifdef MINI_AES_MC_TIMEOUT_EN
                    ct_q    <= to_flag ? 16'h0000 : state_q;
                    err_q   <= to_flag;
                    to_flag <= 1'b0;
`else
                    ct_q    <= state_q;
`endif
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    st      <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.ct    = ct_q;
    assign bus.done  = done_q;
    assign bus.mc_c  = state_q;
    assign bus.mc_ld = mc_ld_q;

endmodule

// File: tb/tb_mini_aes_ctrl.sv
// Scoreboard bench for mini_aes_ctrl: directed vectors with a behavioural Mix_Column.
module tb_mini_aes_ctrl;

    typedef struct {
        logic [15:0] ct;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   gcyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q2[$];
    exp_t q1[$];

    mini_aes_ctrl_if b2();
    mini_aes_ctrl_if b1();

    logic [15:0] ks_in;
    logic [1:0]  ks_r;
    logic [15:0] ks_out;

    mini_aes_ctrl #(.ROUNDS(2), .TIMEOUT(8)) u_dut2 (.clk(clk), .n_rst(n_rst), .bus(b2));
    mini_aes_ctrl #(.ROUNDS(1), .TIMEOUT(8)) u_dut1 (.clk(clk), .n_rst(n_rst), .bus(b1));
    mini_aes_key_step #(.RW(2)) u_ks (.key_prev(ks_in), .rnd(ks_r), .key_next_c(ks_out));

    always #5 clk = ~clk;
    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    function automatic logic [3:0] gm2(input logic [3:0] a);
        return a[3] ? ({a[2:0], 1'b0} ^ 4'h3) : {a[2:0], 1'b0};
    endfunction

    function automatic logic [3:0] gm3(input logic [3:0] a);
        return gm2(a) ^ a;
    endfunction

    // Behavioural Mix_Column: each column times [[3,2],[2,3]] over GF(16), x^4+x+1.
    function automatic logic [15:0] mixcol(input logic [15:0] c);
        return {gm3(c[15:12]) ^ gm2(c[11:8]), gm2(c[15:12]) ^ gm3(c[11:8]),
                gm3(c[7:4])   ^ gm2(c[3:0]),  gm2(c[7:4])   ^ gm3(c[3:0])};
    endfunction

    task automatic reset_checks();
        chk("rst_busy",  16'(b2.busy),  16'h0);
        chk("rst_done",  16'(b2.done),  16'h0);
        chk("rst_err",   16'(b2.err),   16'h0);
        chk("rst_mc_ld", 16'(b2.mc_ld), 16'h0);
        chk("rst_ct",    b2.ct,         16'h0000);
        chk("rst_mc_c",  b2.mc_c,       16'h0000);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    // ROUNDS=2 transaction on pt=9C63, key=C3F0; L=0 means Mix_Column never answers.
    task automatic run2(input int L, input bit spur, input bit bump, input int abort_at,
                        input bit expect_done, input logic [15:0] exp_ct, input bit exp_err,
                        input int exp_lat);
        int          cyc;
        int          dn_at;
        int          ld_cnt;
        bit          waiting;
        bit          stable;
        logic [15:0] ld_val;
        logic [15:0] mcd;
        exp_t        e;
        cyc = 0; dn_at = -1; ld_cnt = 0; waiting = 1'b0; stable = 1'b1;
        ld_val = 16'h0; mcd = 16'h0;
        b2.pt = 16'h9C63; b2.key = 16'hC3F0; b2.start = 1'b1;
        if (expect_done) begin
            e.ct = exp_ct; e.err = exp_err; e.lat = exp_lat; e.t0 = gcyc;
            q2.push_back(e);
        end
        @(posedge clk); #1;
        b2.start = 1'b0; b2.pt = 16'h0; b2.key = 16'h0;
        cyc = 1;
        while (b2.busy === 1'b1 && cyc < 120) begin
            b2.start = (bump && cyc == 2);
            if (waiting && b2.mc_c !== ld_val) stable = 1'b0;
            if (b2.mc_ld === 1'b1) begin
                ld_cnt++;
                ld_val  = b2.mc_c;
                mcd     = mixcol(b2.mc_c);
                waiting = 1'b1;
                if (L > 0) dn_at = cyc + L;
            end
            if (cyc == dn_at) begin
                b2.mc_dn = 1'b1; b2.mc_d = mcd; waiting = 1'b0;
            end else if (spur && cyc == 2) begin
                b2.mc_dn = 1'b1; b2.mc_d = 16'hFFFF;
            end else begin
                b2.mc_dn = 1'b0; b2.mc_d = 16'h0;
            end
            if (cyc == abort_at) n_rst = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                reset_checks();
                n_rst = 1'b1;
                waiting = 1'b0;
            end
        end
        b2.start = 1'b0; b2.mc_dn = 1'b0; b2.mc_d = 16'h0;
        if (ld_cnt > 0) chk("mc_c_at_load", ld_val, 16'hF1A7);
        if (abort_at < 0) begin
            chk("mc_ld_pulses", 16'(ld_cnt), 16'd1);
            chk("mc_c_stable", 16'(stable), 16'd1);
        end
        if (b2.busy === 1'b0) repeat (4) @(posedge clk);
        #1;
    endtask

    // ROUNDS=1 transactions back to back; the second start is issued in the done cycle.
    task automatic run1_b2b();
        int   cyc;
        int   ld_cnt;
        bit   second;
        exp_t e;
        ld_cnt = 0; second = 1'b0;
        b1.pt = 16'h9C63; b1.key = 16'hC3F0; b1.start = 1'b1;
        e.ct = 16'hC158; e.err = 1'b0; e.lat = 6; e.t0 = gcyc;
        q1.push_back(e);
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (cyc = 1; cyc < 20; cyc++) begin
            if (b1.mc_ld === 1'b1) ld_cnt++;
            if (b1.done === 1'b1 && !second) begin
                second = 1'b1;
                b1.start = 1'b1;
                e.t0 = gcyc;
                q1.push_back(e);
            end else begin
                b1.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        b1.start = 1'b0;
        chk("r1_second_start", 16'(second), 16'd1);
        chk("r1_mc_ld_pulses", 16'(ld_cnt), 16'd0);
    endtask

    // Monitor for the ROUNDS=2 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b2.err === 1'b1 && b2.done !== 1'b1) chk("r2_err_without_done", 16'(b2.err), 16'h0);
            if (b2.done === 1'b1) begin
                if (q2.size() == 0) begin
                    chk("r2_unexpected_done", 16'(b2.done), 16'h0);
                end else begin
                    e = q2.pop_front();
                    chk("r2_ct", b2.ct, e.ct);
                    chk("r2_err", 16'(b2.err), 16'(e.err));
                    chk("r2_latency", 16'(gcyc - e.t0 + 1), 16'(e.lat));
                end
            end
        end
    end

    // Monitor for the ROUNDS=1 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b1.done === 1'b1) begin
                if (q1.size() == 0) begin
                    chk("r1_unexpected_done", 16'(b1.done), 16'h0);
                end else begin
                    e = q1.pop_front();
                    chk("r1_ct", b1.ct, e.ct);
                    chk("r1_err", 16'(b1.err), 16'h0);
                    chk("r1_latency", 16'(gcyc - e.t0 + 1), 16'(e.lat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected under 20000", gcyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        b2.start = 1'b0; b2.pt = 16'h0; b2.key = 16'h0; b2.mc_d = 16'h0; b2.mc_dn = 1'b0;
        b1.start = 1'b0; b1.pt = 16'h0; b1.key = 16'h0; b1.mc_d = 16'h0; b1.mc_dn = 1'b0;
        ks_in = 16'hC3F0; ks_r = 2'd1;

        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        chk("r1_rst_busy", 16'(b1.busy), 16'h0);
        n_rst = 1'b1;

        chk("key_round1", ks_out, 16'h30FF);
        ks_in = 16'h30FF; ks_r = 2'd2;
        #1;
        chk("key_round2", ks_out, 16'h6696);

        @(posedge clk); #1;
        run2(1, 1'b0, 1'b0, -1, 1'b1, 16'h72C6, 1'b0, 10);
        run2(5, 1'b0, 1'b0, -1, 1'b1, 16'h72C6, 1'b0, 14);
        run2(2, 1'b1, 1'b1, -1, 1'b1, 16'h72C6, 1'b0, 11);

        chk("ct_held_before_abort", b2.ct, 16'h72C6);
        run2(20, 1'b0, 1'b0, 6, 1'b0, 16'h0, 1'b0, 0);
        run2(1, 1'b0, 1'b0, -1, 1'b1, 16'h72C6, 1'b0, 10);

`ifdef MINI_AES_MC_TIMEOUT_EN
        run2(0, 1'b0, 1'b0, -1, 1'b1, 16'h0000, 1'b1, 14);
        chk("timeout_idle_busy", 16'(b2.busy), 16'h0);
`else
        run2(0, 1'b0, 1'b0, -1, 1'b0, 16'h0, 1'b0, 0);
        chk("no_timeout_busy_held", 16'(b2.busy), 16'h1);
        do_reset();
`endif

        run1_b2b();

        repeat (4) @(posedge clk);
        #1;
        chk("r2_pending_at_end", 16'(q2.size()), 16'd0);
        chk("r1_pending_at_end", 16'(q1.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mini_aes_ctrl.md
# mini_aes_ctrl

Round sequencer for the 16-bit Mini-AES encryption datapath. It accepts a plaintext and a cipher key, and generates round keys on the fly. It performs NibbleSub, ShiftRow and KeyAddition internally. For every non-final round it hands the state to the external `Mix_Column` block over its `ld`/`dn` handshake. It sits between the top-level command interface and `Mix_Column`, and owns all round sequencing.

## Interface
Parameters:
- `ROUNDS`, 2: total rounds, legal range 1..8. The final round skips MixColumn.
- `TIMEOUT`, 64: maximum cycles spent in MC_WAIT. Used only with `MINI_AES_MC_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `n_rst`  in  1: reset, synchronous and active-low.
- `start`  in  1: begin encryption. Sampled only in IDLE.
- `pt`  in  16: plaintext, captured on accepted `start`.
- `key`  in  16: cipher key K0, captured on accepted `start`.
- `busy`  out  1: high in every state except IDLE.
- `ct`  out  16: ciphertext, held until the next accepted `start`.
- `done`  out  1: one-cycle pulse when `ct` is valid.
- `err`  out  1: one-cycle pulse, coincident with `done`, on MixColumn timeout.
- `mc_c`  out  16: state word driven to `Mix_Column`.
- `mc_ld`  out  1: one-cycle load pulse to `Mix_Column`.
- `mc_d`  in  16: `Mix_Column` result.
- `mc_dn`  in  1: `Mix_Column` result valid.

## Operation
- Nibble order: a0=[15:12], a1=[11:8], a2=[7:4], a3=[3:0]. Columns are (a0,a1) and (a2,a3).
- S-box, input 0..F maps to E,4,D,1,2,F,B,8,3,A,6,C,5,9,0,7.
- ShiftRow swaps a1 and a3.
- Key step for round r, with w0..w3 the previous key:
  - w4=w0^S(w3)^rcon(r), w5=w1^w4, w6=w2^w5, w7=w3^w6.
  - rcon sequence is 1,2,4,8,3,6,C,B.
- State machine:
  - IDLE: on `start`, capture `pt`/`key`; go to ADD0.
  - ADD0: state←pt^K0; round counter r←1; go to SUB.
  - SUB: state←ShiftRow(S(state)); key←KeyStep(key,r). If r<ROUNDS go to MC_LOAD, else go to ADDK.
  - MC_LOAD: `mc_ld`=1; go to MC_WAIT.
  - MC_WAIT: on the first cycle with `mc_dn`=1, state←`mc_d`; go to ADDK.
  - ADDK: state←state^key. If r==ROUNDS go to DONE, else r←r+1 and go to SUB.
  - DONE: `ct`←state; `done`=1; go to IDLE.
- `mc_c` equals the state register. It is stable from MC_LOAD until `mc_dn` is sampled.
- `mc_dn` is ignored outside MC_WAIT.
- `start` is ignored while `busy`.
- The round counter is $clog2(ROUNDS+1) bits wide.
- All XOR arithmetic is 16 bits wide with no carries.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `mc_ld`=0, `ct`=0, `mc_c`=0, state=IDLE.
- Reset asserted mid-operation abandons the encryption immediately. No `done` is issued and `ct` returns to 0.
- Latency from the `start` cycle to the `done` cycle: 4+ROUNDS*2 + (ROUNDS−1)*(1+L) cycles, where L is the number of cycles from `mc_ld` to `mc_dn`, L≥1. With ROUNDS=2 and L=1, `done` comes 10 cycles after `start`.
- A new `start` is accepted in the cycle after DONE, when the block is back in IDLE.
- `mc_dn` already high in the first MC_WAIT cycle is accepted, so L=1 is legal.

## Configuration
- `MINI_AES_MC_TIMEOUT_EN` defined:
  - A counter runs in MC_WAIT.
  - If TIMEOUT cycles elapse without `mc_dn`, go to DONE with `ct`=0 and pulse `err` together with `done`.
- Not defined:
  - MC_WAIT waits indefinitely.
  - `err` is tied 0 and no counter is synthesized.

## Structure
- Package `mini_aes_pkg` holds:
  - the nibble typedef and the state enum;
  - the `sbox` lookup function and the `rcon` function;
  - the `shift_row` and `nib_sub16` functions.
- Sub-module `mini_aes_key_step` (combinational): inputs are the previous key and r; output is the next round key.

## Test plan
- Known vector: pt=9C63, key=C3F0, ROUNDS=2, behavioural Mix_Column with L=1.
  - `ct`=72C6 and `done` arrive at cycle +10.
  - Intermediate `mc_c`=F1A7; round keys are 30FF and 6696.
- Same vector with Mix_Column L=5.
  - `ct`=72C6 at cycle +14; `mc_c` stable throughout MC_WAIT; exactly one `mc_ld` pulse.
- `start` pulsed while busy.
  - Ignored; single `done`; a spurious `mc_dn` in SUB does not alter the state.
- `n_rst` low during MC_WAIT.
  - The next cycle shows all outputs at reset values and no `done`.
  - A fresh `start` then yields 72C6.
- With `MINI_AES_MC_TIMEOUT_EN`, TIMEOUT=8, `mc_dn` held 0.
  - `err` and `done` pulse together after 8 MC_WAIT cycles, with `ct`=0, then the block returns to IDLE.
  - Without the macro, `busy` stays high indefinitely.
- ROUNDS=1, pt=9C63, key=C3F0.
  - `mc_ld` is never asserted; `ct`=F1A7^30FF=C158 at cycle +6.
